// File: rtl/sddr_pkg.sv
// rtl/sddr_pkg.sv - shared types and geometry helpers for the simple DDR controller
package sddr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_RESP    = 3'd4
    } adapter_state_e;

    localparam int CPU_WORD_BITS = 32;

    // Width of one full burst line in bits.
    function automatic int line_bits(input int burst_length, input int data_bits);
        return burst_length * data_bits;
    endfunction

    // Number of byte-offset bits inside one line.
    function automatic int off_bits(input int burst_length, input int data_bits);
        return $clog2((burst_length * data_bits) / 8);
    endfunction

    // Index of the 32-bit word inside its line for a byte address.
    function automatic int word_sel(input logic [31:0] byte_addr, input int offb);
        return int'((byte_addr >> 2) & ((32'd1 << (offb - 2)) - 32'd1));
    endfunction

endpackage

// File: rtl/sddr_line_merge.sv
// rtl/sddr_line_merge.sv - byte-masked word merge into a line, plus word extraction
module sddr_line_merge
    import sddr_pkg::*;
#(
    parameter int LINE_BITS = 128,
    localparam int WORDS     = LINE_BITS / CPU_WORD_BITS,
    localparam int WSEL_BITS = $clog2(WORDS)
) (
    input  logic [LINE_BITS-1:0]     line_i,
    input  logic [WSEL_BITS-1:0]     word_sel_i,
    input  logic [CPU_WORD_BITS-1:0] data_i,
    input  logic [3:0]               be_i,
    output logic [LINE_BITS-1:0]     line_o,
    output logic [CPU_WORD_BITS-1:0] word_o,
    output logic [CPU_WORD_BITS-1:0] merged_word_o
);

    // Replace the enabled bytes of the selected word; also expose old and new word
    always_comb begin
        int base;
        base          = int'(word_sel_i) * CPU_WORD_BITS;
        line_o        = line_i;
        word_o        = line_i[base +: CPU_WORD_BITS];
        merged_word_o = word_o;
        for (int b = 0; b < 4; b++) begin
            if (be_i[b]) begin
                line_o[base + 8*b +: 8]   = data_i[8*b +: 8];
                merged_word_o[8*b +: 8]   = data_i[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/sddr_line_adapter.sv
// rtl/sddr_line_adapter.sv - CPU word port to full-line DDR burst commands with a one-line read buffer
module sddr_line_adapter
    import sddr_pkg::*;
#(
    parameter int BANK_BITS    = 3,
    parameter int ROW_BITS     = 13,
    parameter int COL_BITS     = 10,
    parameter int DATA_BITS    = 16,
    parameter int BURST_LENGTH = 8,
    localparam int LINE_BITS    = line_bits(BURST_LENGTH, DATA_BITS),
    localparam int OFF_BITS     = off_bits(BURST_LENGTH, DATA_BITS),
    localparam int ADDRESS_BITS = BANK_BITS + ROW_BITS + COL_BITS + $clog2(DATA_BITS / 8),
    localparam int WSEL_BITS    = $clog2(LINE_BITS / CPU_WORD_BITS),
    localparam int TAG_BITS     = ADDRESS_BITS - OFF_BITS
) (
    input  logic                     cpu_clock_i,
    input  logic                     reset_i,
    input  logic                     invalidate_i,
    input  logic                     cpu_req_valid,
    output logic                     cpu_req_ack,
    input  logic                     cpu_req_write,
    input  logic [ADDRESS_BITS-1:0]  cpu_req_address,
    input  logic [31:0]              cpu_req_data,
    input  logic [3:0]               cpu_req_be,
    output logic                     cpu_rsp_valid,
    output logic [31:0]              cpu_rsp_data,
    output logic                     data_cmd_valid,
    input  logic                     data_cmd_ack,
    output logic [ADDRESS_BITS-1:0]  data_cmd_address,
    output logic                     data_cmd_write,
    output logic [LINE_BITS-1:0]     data_cmd_data_o,
    input  logic                     data_rsp_ready,
    input  logic [LINE_BITS-1:0]     data_rsp_data_i
);

    adapter_state_e state_q, state_d;

    logic                    line_valid_q;
    logic                    poison_q;
    logic [TAG_BITS-1:0]     tag_q;
    logic [LINE_BITS-1:0]    line_q;
    logic [LINE_BITS-1:0]    cmd_line_q;
    logic [ADDRESS_BITS-1:0] req_addr_q;
    logic [31:0]             req_data_q;
    logic [3:0]              req_be_q;
    logic                    req_write_q;
    logic [31:0]             rsp_data_q;

    logic accept;
    logic hit;
    logic cmd_fire;

    logic [LINE_BITS-1:0] m_line;
    logic [WSEL_BITS-1:0] m_sel;
    logic [31:0]          m_data;
    logic [3:0]           m_be;
    logic [LINE_BITS-1:0] m_line_merged;
    logic [31:0]          m_word_old;
    logic [31:0]          m_word_new;

    assign accept   = cpu_req_valid && cpu_req_ack;
    assign hit      = line_valid_q && (tag_q == cpu_req_address[ADDRESS_BITS-1:OFF_BITS]) && !invalidate_i;
    assign cmd_fire = data_cmd_valid && data_cmd_ack;

    // One merge unit: in IDLE it works on the buffer and the live request, otherwise on the fetched line
    always_comb begin
        if (state_q == ST_IDLE) begin
            m_line = line_q;
            m_sel  = WSEL_BITS'(word_sel(32'(cpu_req_address), OFF_BITS));
            m_data = cpu_req_data;
            m_be   = cpu_req_be;
        end else begin
            m_line = data_rsp_data_i;
            m_sel  = WSEL_BITS'(word_sel(32'(req_addr_q), OFF_BITS));
            m_data = req_data_q;
            m_be   = req_be_q;
        end
    end

    sddr_line_merge #(
        .LINE_BITS(LINE_BITS)
    ) u_merge (
        .line_i        (m_line),
        .word_sel_i    (m_sel),
        .data_i        (m_data),
        .be_i          (m_be),
        .line_o        (m_line_merged),
        .word_o        (m_word_old),
        .merged_word_o (m_word_new)
    );

    // State register
    always_ff @(posedge cpu_clock_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!cpu_req_write) begin
                        state_d = hit ? ST_RESP : ST_RD_REQ;
                    end else if (cpu_req_be == 4'b0000) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = hit ? ST_WR_REQ : ST_RD_REQ;
                    end
                end
            end
            ST_RD_REQ:  if (cmd_fire) state_d = ST_RD_WAIT;
            ST_RD_WAIT: if (data_rsp_ready) state_d = req_write_q ? ST_WR_REQ : ST_RESP;
            ST_WR_REQ:  if (cmd_fire) state_d = ST_RESP;
            ST_RESP:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; command address is forced to zero when no command is offered
    always_comb begin
        cpu_req_ack      = (state_q == ST_IDLE) && !reset_i;
        cpu_rsp_valid    = (state_q == ST_RESP);
        data_cmd_valid   = (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ);
        data_cmd_write   = (state_q == ST_WR_REQ);
        data_cmd_address = '0;
        if (data_cmd_valid) begin
            data_cmd_address = {req_addr_q[ADDRESS_BITS-1:OFF_BITS], {OFF_BITS{1'b0}}};
        end
        data_cmd_data_o  = cmd_line_q;
        cpu_rsp_data     = rsp_data_q;
    end

    // Request latch, line buffer, tag/valid and poison tracking
    always_ff @(posedge cpu_clock_i) begin
        if (reset_i) begin
            line_valid_q <= 1'b0;
            poison_q     <= 1'b0;
            tag_q        <= '0;
            line_q       <= '0;
            cmd_line_q   <= '0;
            req_addr_q   <= '0;
            req_data_q   <= '0;
            req_be_q     <= '0;
            req_write_q  <= 1'b0;
            rsp_data_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (invalidate_i) line_valid_q <= 1'b0;
                    if (accept) begin
                        req_addr_q  <= cpu_req_address;
                        req_data_q  <= cpu_req_data;
                        req_be_q    <= cpu_req_be;
                        req_write_q <= cpu_req_write;
                        if (!cpu_req_write) begin
                            if (hit) rsp_data_q <= m_word_old;
                        end else if (cpu_req_be == 4'b0000) begin
                            rsp_data_q <= hit ? m_word_old : 32'd0;
                        end else if (hit) begin
                            line_q     <= m_line_merged;
                            cmd_line_q <= m_line_merged;
                            rsp_data_q <= m_word_new;
                        end
                    end
                end
                ST_RD_REQ: begin
                    if (invalidate_i) poison_q <= 1'b1;
                end
                ST_RD_WAIT: begin
                    if (data_rsp_ready) begin
                        // An invalidate landing on the fill cycle must also keep the line invalid
                        line_q       <= req_write_q ? m_line_merged : data_rsp_data_i;
                        cmd_line_q   <= m_line_merged;
                        tag_q        <= req_addr_q[ADDRESS_BITS-1:OFF_BITS];
                        line_valid_q <= !(poison_q || invalidate_i);
                        poison_q     <= 1'b0;
                        rsp_data_q   <= req_write_q ? m_word_new : m_word_old;
                    end else if (invalidate_i) begin
                        poison_q <= 1'b1;
                    end
                end
                default: begin
                    if (invalidate_i) line_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sddr_line_adapter.sv
// tb/tb_sddr_line_adapter.sv - directed self-checking bench for sddr_line_adapter
module tb_sddr_line_adapter;

    localparam int AW         = 27;
    localparam int LB         = 128;
    localparam int RESP_DELAY = 6;
    localparam int BUDGET     = 200;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          invalidate_i;
    logic          cpu_req_valid;
    logic          cpu_req_ack;
    logic          cpu_req_write;
    logic [AW-1:0] cpu_req_address;
    logic [31:0]   cpu_req_data;
    logic [3:0]    cpu_req_be;
    logic          cpu_rsp_valid;
    logic [31:0]   cpu_rsp_data;
    logic          data_cmd_valid;
    logic          data_cmd_ack;
    logic [AW-1:0] data_cmd_address;
    logic          data_cmd_write;
    logic [LB-1:0] data_cmd_data_o;
    logic          data_rsp_ready;
    logic [LB-1:0] data_rsp_data_i;

    logic [LB-1:0] rsp_line;

    int tests_run = 0;
    int tests_failed = 0;

    int            cmd_count = 0;
    int            rsp_count = 0;
    logic [AW-1:0] last_addr = '0;
    logic          last_write = 1'b0;
    logic [LB-1:0] last_data = '0;
    logic [31:0]   last_rsp = '0;

    always #5 clk = ~clk;

    sddr_line_adapter dut (
        .cpu_clock_i      (clk),
        .reset_i          (reset_i),
        .invalidate_i     (invalidate_i),
        .cpu_req_valid    (cpu_req_valid),
        .cpu_req_ack      (cpu_req_ack),
        .cpu_req_write    (cpu_req_write),
        .cpu_req_address  (cpu_req_address),
        .cpu_req_data     (cpu_req_data),
        .cpu_req_be       (cpu_req_be),
        .cpu_rsp_valid    (cpu_rsp_valid),
        .cpu_rsp_data     (cpu_rsp_data),
        .data_cmd_valid   (data_cmd_valid),
        .data_cmd_ack     (data_cmd_ack),
        .data_cmd_address (data_cmd_address),
        .data_cmd_write   (data_cmd_write),
        .data_cmd_data_o  (data_cmd_data_o),
        .data_rsp_ready   (data_rsp_ready),
        .data_rsp_data_i  (data_rsp_data_i)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Controller-side observer: accepted commands and response pulses
    always @(negedge clk) begin
        if (data_cmd_valid && data_cmd_ack) begin
            cmd_count  <= cmd_count + 1;
            last_addr  <= data_cmd_address;
            last_write <= data_cmd_write;
            last_data  <= data_cmd_data_o;
        end
        if (cpu_rsp_valid) begin
            rsp_count <= rsp_count + 1;
            last_rsp  <= cpu_rsp_data;
        end
    end

    // Controller read-data model: returns rsp_line a fixed delay after a read command
    initial begin
        data_rsp_ready  = 1'b0;
        data_rsp_data_i = '0;
        forever begin
            @(negedge clk);
            if (data_cmd_valid && data_cmd_ack && !data_cmd_write) begin
                repeat (RESP_DELAY) @(posedge clk);
                #1;
                data_rsp_ready  = 1'b1;
                data_rsp_data_i = rsp_line;
                @(posedge clk);
                #1;
                data_rsp_ready  = 1'b0;
            end
        end
    end

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_req(input string tag, input logic wr, input logic [AW-1:0] addr,
                             input logic [31:0] data, input logic [3:0] be);
        int n;
        @(posedge clk);
        #1;
        cpu_req_valid   = 1'b1;
        cpu_req_write   = wr;
        cpu_req_address = addr;
        cpu_req_data    = data;
        cpu_req_be      = be;
        n = 0;
        while (n < BUDGET) begin
            @(negedge clk);
            n++;
            if (cpu_req_ack) break;
        end
        if (n >= BUDGET) chk({tag, "_accept_timeout"}, 128'(0), 128'(1));
        @(posedge clk);
        #1;
        cpu_req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, output int lat);
        int n;
        logic seen;
        n = 0;
        seen = 1'b0;
        while (n < BUDGET && !seen) begin
            @(negedge clk);
            n++;
            if (cpu_rsp_valid) seen = 1'b1;
        end
        if (!seen) chk({tag, "_rsp_timeout"}, 128'(0), 128'(1));
        lat = n;
        settle(2);
    endtask

    initial begin
        int c0, r0, lat;
        logic stall_bad;

        reset_i         = 1'b1;
        invalidate_i    = 1'b0;
        cpu_req_valid   = 1'b0;
        cpu_req_write   = 1'b0;
        cpu_req_address = '0;
        cpu_req_data    = '0;
        cpu_req_be      = '0;
        data_cmd_ack    = 1'b1;
        rsp_line        = '0;

        settle(3);
        chk("rst_rsp_valid", 128'(cpu_rsp_valid), 128'(0));
        chk("rst_cmd_valid", 128'(data_cmd_valid), 128'(0));
        chk("rst_cmd_write", 128'(data_cmd_write), 128'(0));
        chk("rst_cmd_addr", 128'(data_cmd_address), 128'(0));
        chk("rst_cmd_data", data_cmd_data_o, 128'(0));
        chk("rst_rsp_data", 128'(cpu_rsp_data), 128'(0));
        chk("rst_ack_low", 128'(cpu_req_ack), 128'(0));
        reset_i = 1'b0;
        #1;
        chk("ack_after_rst", 128'(cpu_req_ack), 128'(1));

        // read miss fills the line
        rsp_line = 128'h0F0E0D0C_DDCCBBAA_44332211_08070605;
        c0 = cmd_count; r0 = rsp_count;
        start_req("t1", 1'b0, 27'h44, 32'h0, 4'h0);
        wait_rsp("t1", lat);
        chk("t1_cmds", 128'(cmd_count - c0), 128'(1));
        chk("t1_addr", 128'(last_addr), 128'(27'h40));
        chk("t1_write", 128'(last_write), 128'(0));
        chk("t1_data", 128'(last_rsp), 128'(32'h44332211));
        chk("t1_pulses", 128'(rsp_count - r0), 128'(1));

        // read hits in the same line
        c0 = cmd_count; r0 = rsp_count;
        start_req("t2a", 1'b0, 27'h40, 32'h0, 4'h0);
        wait_rsp("t2a", lat);
        chk("t2a_lat", 128'(lat), 128'(1));
        chk("t2a_data", 128'(last_rsp), 128'(32'h08070605));
        start_req("t2b", 1'b0, 27'h47, 32'h0, 4'h0);
        wait_rsp("t2b", lat);
        chk("t2b_lat", 128'(lat), 128'(1));
        chk("t2b_data", 128'(last_rsp), 128'(32'h44332211));
        chk("t2_cmds", 128'(cmd_count - c0), 128'(0));
        chk("t2_pulses", 128'(rsp_count - r0), 128'(2));

        // write with no enabled bytes: immediate completion, no DDR traffic
        c0 = cmd_count;
        start_req("be0", 1'b1, 27'h40, 32'h12345678, 4'h0);
        wait_rsp("be0", lat);
        chk("be0_lat", 128'(lat), 128'(1));
        chk("be0_cmds", 128'(cmd_count - c0), 128'(0));

        // write hit: bytes 8 and 10 of the line change
        c0 = cmd_count; r0 = rsp_count;
        start_req("t3", 1'b1, 27'h48, 32'hDEADBEEF, 4'b0101);
        wait_rsp("t3", lat);
        chk("t3_cmds", 128'(cmd_count - c0), 128'(1));
        chk("t3_write", 128'(last_write), 128'(1));
        chk("t3_addr", 128'(last_addr), 128'(27'h40));
        chk("t3_line", last_data, 128'h0F0E0D0C_DDADBBEF_44332211_08070605);
        chk("t3_rsp", 128'(last_rsp), 128'(32'hDDADBBEF));
        chk("t3_pulses", 128'(rsp_count - r0), 128'(1));
        c0 = cmd_count;
        start_req("t3r", 1'b0, 27'h48, 32'h0, 4'h0);
        wait_rsp("t3r", lat);
        chk("t3r_lat", 128'(lat), 128'(1));
        chk("t3r_data", 128'(last_rsp), 128'(32'hDDADBBEF));
        chk("t3r_cmds", 128'(cmd_count - c0), 128'(0));

        // write miss with the controller stalling for 20 cycles
        rsp_line = 128'h33333333_22222222_11111111_12345678;
        c0 = cmd_count; r0 = rsp_count;
        data_cmd_ack = 1'b0;
        start_req("t4", 1'b1, 27'h1230, 32'hCAFEF00D, 4'b1100);
        stall_bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (!data_cmd_valid || data_cmd_write || data_cmd_address !== 27'h1230) stall_bad = 1'b1;
        end
        chk("t4_stall_hold", 128'(stall_bad), 128'(0));
        chk("t4_stall_cmds", 128'(cmd_count - c0), 128'(0));
        @(posedge clk);
        #1;
        data_cmd_ack = 1'b1;
        wait_rsp("t4", lat);
        chk("t4_cmds", 128'(cmd_count - c0), 128'(2));
        chk("t4_write", 128'(last_write), 128'(1));
        chk("t4_addr", 128'(last_addr), 128'(27'h1230));
        chk("t4_line", last_data, 128'h33333333_22222222_11111111_CAFE5678);
        chk("t4_rsp", 128'(last_rsp), 128'(32'hCAFE5678));
        chk("t4_pulses", 128'(rsp_count - r0), 128'(1));

        // invalidate while the fill is outstanding: answered, but not retained
        rsp_line = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
        r0 = rsp_count;
        start_req("t5", 1'b0, 27'h2044, 32'h0, 4'h0);
        settle(1);
        invalidate_i = 1'b1;
        settle(1);
        invalidate_i = 1'b0;
        wait_rsp("t5", lat);
        chk("t5_data", 128'(last_rsp), 128'(32'hA1A1A1A1));
        chk("t5_pulses", 128'(rsp_count - r0), 128'(1));
        c0 = cmd_count;
        start_req("t5r", 1'b0, 27'h2040, 32'h0, 4'h0);
        wait_rsp("t5r", lat);
        chk("t5r_cmds", 128'(cmd_count - c0), 128'(1));
        chk("t5r_data", 128'(last_rsp), 128'(32'hA0A0A0A0));

        // reset while waiting for the fill; the late line is ignored
        rsp_line = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
        r0 = rsp_count;
        start_req("t6", 1'b0, 27'h3000, 32'h0, 4'h0);
        settle(1);
        reset_i = 1'b1;
        #1;
        chk("t6_ack_in_rst", 128'(cpu_req_ack), 128'(0));
        settle(1);
        reset_i = 1'b0;
        #1;
        chk("t6_ack_release", 128'(cpu_req_ack), 128'(1));
        settle(10);
        chk("t6_no_rsp", 128'(rsp_count - r0), 128'(0));
        chk("t6_ack_idle", 128'(cpu_req_ack), 128'(1));
        c0 = cmd_count;
        start_req("t6r", 1'b0, 27'h3000, 32'h0, 4'h0);
        wait_rsp("t6r", lat);
        chk("t6r_cmds", 128'(cmd_count - c0), 128'(1));
        chk("t6r_data", 128'(last_rsp), 128'(32'hB0B0B0B0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
